sha256_round_ctrl: RTL and testbench
====================================

Name: sha256_round_ctrl

Overview:
- Sequences the 64 compression rounds of one SHA-256 block over the working variables a..h.
- Per round, T2 = Sigma0(a) + Maj(a,b,c) and T1 = h + Sigma1(e) + Ch(e,f,g) + K[t] + W[t] are computed internally.
- Message words W[t] arrive from the message-schedule unit over a valid/ready handshake; the round constants K[t] come from an internal 64x32 ROM.
- Sits between the host or Versat configuration path, which supplies the chaining value, and the message-schedule source. Produces the updated chaining value.

Parameters:
- DATA_W, 32, word width; only 32 is supported.
- FEEDFWD, 1, when 1 h_out = h_in + final a..h (mod 2^32 per word); when 0 h_out = final a..h.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a block; sampled only in IDLE.
- h_in  input  256  chaining value H0..H7, H0 in bits [255:224]; sampled on accepted start.
- w_data  input  32  message word W[t].
- w_valid  input  1  w_data valid.
- w_ready  output  1  controller accepts W this cycle.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse, h_out valid.
- round  output  6  index t of the next round to execute.
- h_out  output  256  result digest, same packing as h_in; held until the next accepted start.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, w_ready=0, round=0, h_out=0; a..h and the saved h_in are cleared. A reset mid-block aborts it; no done is produced.
- IDLE:
  - start=1 loads a..h from h_in, saves h_in, sets round=0 and goes to ROUND.
  - start=0 stays in IDLE.
  - start is ignored in every state except IDLE.
- ROUND:
  - w_ready=1, busy=1.
  - On w_valid&&w_ready, one round executes in that cycle with K[round] and w_data:
    - h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
    - round increments.
  - With w_valid=0 no state changes (stall of any length).
  - When round 63 is accepted, round wraps to 0 and the state goes to FINAL.
- FINAL: w_ready=0. In this single cycle h_out is registered per the FEEDFWD rule, then done=1 for one cycle, busy=0, and the state returns to IDLE.
- Cycle timing:
  - Accepted start at cycle 0 → ROUND at cycle 1.
  - With w_valid held high: rounds 0..63 accepted in cycles 1..64, done=1 in cycle 66 (FINAL in cycle 65).
  - Minimum start-to-done latency is 66 cycles.
- Back-to-back: start is accepted in the cycle done=1 (the state is IDLE then). h_out keeps its value until the next FINAL.
- Arithmetic: all additions are modulo 2^32 with no carry out.
  - Sigma0 = ROTR2^ROTR13^ROTR22.
  - Sigma1 = ROTR6^ROTR11^ROTR25.
  - Ch = (e&f)^(~e&g).
  - Maj = (a&b)^(a&c)^(b&c).
- Simultaneous start and w_valid in IDLE: w_valid is ignored and no W is consumed.
- K ROM: the FIPS 180-4 constants K[0]=0x428a2f98 through K[63]=0xc67178f2, as combinational lookup.

Test Plan:
- Reset: assert rst for 2 cycles mid-ROUND at round=10 → busy=0, w_ready=0, round=0, h_out=0; no done pulse appears.
- Round 0 of "abc":
  - Stimulus: h_in = SHA-256 IV (6a09e667 … 5be0cd19), W0=0x61626380.
  - Required response: after the accept, a=5d6aebcd, e=fa2a4622, h=1f83d9ab, round=1.
- Full "abc" block:
  - Stimulus: IV, 64 bench-computed W words, w_valid held high.
  - Required response: done in cycle 66 after start; h_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Stalls: same block with w_valid toggling pseudo-randomly (about 50% duty) → identical h_out. The done cycle equals start cycle + 2 + the number of ROUND cycles, which is 64 accepted plus the stall cycles.
- FEEDFWD=0: "abc" block → h_out equals h_out(FEEDFWD=1) − IV per word, mod 2^32.
- Protocol edges:
  - start pulsed during ROUND → ignored, result unchanged.
  - start asserted in the done cycle → accepted, busy the next cycle, previous h_out held until the new FINAL.
  - Two consecutive blocks of a 2-block message ("abcdbcdecdef…", 448 bits) → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.

Source files
------------

// File: rtl/sha256_round_ctrl_if.sv
// Host/message-schedule side of the SHA-256 round controller: block start,
// chaining value in/out, and the W[t] valid/ready stream.
interface sha256_round_ctrl_if;
  logic         start;
  logic [255:0] h_in;
  logic [31:0]  w_data;
  logic         w_valid;
  logic         w_ready;
  logic         busy;
  logic         done;
  logic [5:0]   round;
  logic [255:0] h_out;

  modport master (
    output start, h_in, w_data, w_valid,
    input  w_ready, busy, done, round, h_out
  );

  modport slave (
    input  start, h_in, w_data, w_valid,
    output w_ready, busy, done, round, h_out
  );
endinterface

// File: rtl/sha256_round_ctrl.sv
// Runs the 64 SHA-256 compression rounds of one block, one round per accepted
// W word, then produces the updated chaining value.
module sha256_round_ctrl #(
  parameter int DATA_W  = 32,
  parameter bit FEEDFWD = 1'b1
) (
  input logic             clk,
  input logic             rst,
  sha256_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   a, b, c, d, e, f, g, h;
  logic [255:0]        h_saved;
  logic [255:0]        h_out_q;
  logic [5:0]          round_q;
  logic                done_q;
  logic                load, step, finish;
  logic [DATA_W-1:0]   t1, t2;
  logic [255:0]        cur_v, fwd_v;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        if (bus.w_valid) begin
          step = 1'b1;
          if (round_q == 6'd63) state_nxt = FINAL;
        end
      end
      FINAL: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign t1 = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + K_ROM[round_q] + bus.w_data;
  assign t2 = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));

  assign cur_v = {a, b, c, d, e, f, g, h};

  // Feed-forward is a word-wise add; carries must not cross 32-bit lanes.
  always_comb begin
    fwd_v = '0;
    for (int i = 0; i < 8; i++) begin
      fwd_v[i*32 +: 32] = h_saved[i*32 +: 32] + cur_v[i*32 +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {a, b, c, d, e, f, g, h} <= '0;
      h_saved <= '0;
      h_out_q <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= finish;
      if (load) begin
        {a, b, c, d, e, f, g, h} <= bus.h_in;
        h_saved <= bus.h_in;
        round_q <= '0;
      end else if (step) begin
        h <= g;
        g <= f;
        f <= e;
        e <= d + t1;
        d <= c;
        c <= b;
        b <= a;
        a <= t1 + t2;
        round_q <= round_q + 6'd1;
      end
      if (finish) h_out_q <= FEEDFWD ? fwd_v : cur_v;
    end
  end

  assign bus.w_ready = (state == ROUND);
  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.round   = round_q;
  assign bus.h_out   = h_out_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Drives one feed-forward and one raw-output controller with identical traffic
// and scores their digests against a SHA-256 reference model.
module tb_sha256_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] h_in;
  logic [31:0]  w_data;
  logic         w_valid;

  always #5 clk = ~clk;

  sha256_round_ctrl_if bus0 ();
  sha256_round_ctrl_if bus1 ();

  assign bus0.start   = start;
  assign bus0.h_in    = h_in;
  assign bus0.w_data  = w_data;
  assign bus0.w_valid = w_valid;
  assign bus1.start   = start;
  assign bus1.h_in    = h_in;
  assign bus1.w_data  = w_data;
  assign bus1.w_valid = w_valid;

  sha256_round_ctrl #(.DATA_W(32), .FEEDFWD(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sha256_round_ctrl #(.DATA_W(32), .FEEDFWD(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  localparam logic [31:0] K_TB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [511:0] TWO_BLK1 = {
    448'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071,
    8'h80, 56'h0};
  localparam logic [511:0] TWO_BLK2 = {448'h0, 64'h1c0};
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  typedef struct {
    logic [255:0] ff1;
    logic [255:0] ff0;
    int           done_cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [31:0]  w_sched [64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sub_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] - y[i*32 +: 32];
    return r;
  endfunction

  task automatic build_sched(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) w_sched[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w_sched[t-15], 7) ^ rotr(w_sched[t-15], 18) ^ (w_sched[t-15] >> 3);
      s1 = rotr(w_sched[t-2], 17) ^ rotr(w_sched[t-2], 19) ^ (w_sched[t-2] >> 10);
      w_sched[t] = w_sched[t-16] + s0 + w_sched[t-7] + s1;
    end
  endtask

  // Reference compression over the schedule currently held in w_sched.
  function automatic logic [255:0] sha_block(input logic [255:0] hv);
    logic [31:0]  v [8];
    logic [31:0]  t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
      t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TB[t] + w_sched[t];
      s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
      t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hv[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  // Called #1 after a rising edge with both DUTs idle; returns in the FINAL cycle.
  task automatic applyStimulus(input logic [255:0] hin, input logic [511:0] blk,
                               input logic [255:0] exp1, input bit stall,
                               input bit pulse_start, input bit chk_r0, input bit chk_hold,
                               input logic [255:0] prev1, input logic [255:0] prev0);
    exp_t item;
    int   s_cyc, rc, t;
    build_sched(blk);
    start   = 1'b1;
    h_in    = hin;
    w_valid = 1'($urandom_range(0, 1));
    w_data  = $urandom;
    s_cyc   = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    rc    = 0;
    t     = 0;
    while (t < 64 && rc < 4000) begin
      start   = pulse_start && (rc == 20);
      w_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      w_data  = w_valid ? w_sched[t] : $urandom;
      if (rc == 0) begin
        checkOutput("busy_after_start", bus0.busy, 1);
        checkOutput("w_ready_in_round", bus0.w_ready, 1);
        if (chk_hold) begin
          checkOutput("h_out_hold_ff1", bus0.h_out, prev1);
          checkOutput("h_out_hold_ff0", bus1.h_out, prev0);
        end
      end
      @(posedge clk); #1;
      rc++;
      if (w_valid) begin
        t++;
        if (chk_r0 && t == 1) begin
          checkOutput("round0_a", dut0.a, 32'h5d6aebcd);
          checkOutput("round0_e", dut0.e, 32'hfa2a4622);
          checkOutput("round0_h", dut0.h, 32'h1f83d9ab);
          checkOutput("round0_index", bus0.round, 1);
        end
      end
    end
    start   = 1'b0;
    w_valid = 1'b0;
    if (t < 64) begin
      checks++;
      errors++;
      $display("[TB] FAIL feed_timeout: accepted %0d words, required 64", t);
    end else begin
      item.ff1      = exp1;
      item.ff0      = sub_words(exp1, hin);
      item.done_cyc = s_cyc + 2 + rc;
      sb.push_back(item);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding block.
  always @(negedge clk) begin
    if (bus0.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("h_out_ff1", bus0.h_out, e.ff1);
        checkOutput("h_out_ff0", bus1.h_out, e.ff0);
        checkOutput("done_cycle", 256'(cyc), 256'(e.done_cyc));
        checkOutput("done_ff0", bus1.done, 1);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] prev1, prev0, mid, hr, er;
    logic [511:0] br;
    rst     = 1'b1;
    start   = 1'b0;
    h_in    = '0;
    w_data  = '0;
    w_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_busy", bus0.busy, 0);
    checkOutput("reset_done", bus0.done, 0);
    checkOutput("reset_w_ready", bus0.w_ready, 0);
    checkOutput("reset_round", bus0.round, 0);
    checkOutput("reset_h_out", bus0.h_out, 0);
    @(posedge clk); #1;

    // Abort a block at round 10 with a two-cycle reset.
    for (int i = 0; i < 16; i++) br[i*32 +: 32] = $urandom;
    build_sched(br);
    start = 1'b1;
    h_in  = {8{$urandom}};
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      w_valid = 1'b1;
      w_data  = w_sched[i];
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    checkOutput("abort_round_before_reset", bus0.round, 10);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("abort_busy", bus0.busy, 0);
    checkOutput("abort_w_ready", bus0.w_ready, 0);
    checkOutput("abort_round", bus0.round, 0);
    checkOutput("abort_h_out", bus0.h_out, 0);
    checkOutput("abort_w_ready_ff0", bus1.w_ready, 0);
    repeat (3) @(posedge clk);
    #1;

    applyStimulus(IV, ABC_BLK, ABC_DIG, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    repeat (4) @(posedge clk);
    #1;

    prev1 = ABC_DIG;
    prev0 = sub_words(ABC_DIG, IV);
    applyStimulus(IV, ABC_BLK, ABC_DIG, 1'b1, 1'b1, 1'b0, 1'b1, prev1, prev0);
    @(posedge clk); #1;

    build_sched(TWO_BLK1);
    mid = sha_block(IV);
    applyStimulus(IV, TWO_BLK1, mid, 1'b1, 1'b0, 1'b0, 1'b1, prev1, prev0);
    @(posedge clk); #1;
    prev1 = mid;
    prev0 = sub_words(mid, IV);
    applyStimulus(mid, TWO_BLK2, TWO_DIG, 1'b1, 1'b0, 1'b0, 1'b1, prev1, prev0);
    prev1 = TWO_DIG;
    prev0 = sub_words(TWO_DIG, mid);

    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (n % 2 == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      for (int i = 0; i < 8; i++) hr[i*32 +: 32] = $urandom;
      for (int i = 0; i < 16; i++) br[i*32 +: 32] = $urandom;
      build_sched(br);
      er = sha_block(hr);
      applyStimulus(hr, br, er, n != 1, n == 3, 1'b0, 1'b1, prev1, prev0);
      prev1 = er;
      prev0 = sub_words(er, hr);
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 256'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
